dsi_packet_scheduler: RTL

- Shares one `dsi_packer` input port between two packet requesters: video (requester 0) and host command (requester 1).
- For each packet it arbitrates, then emits the DSI header (DI, WC/data, ECC) into the packer byte stream.
- For long packets it then streams the granted requester's payload, appends a 2-byte checksum footer of 0x0000, and flushes the packer when traffic goes idle.

---
 rtl/dsi_pkg.sv | 16 +
 rtl/dsi_packet_scheduler_if.sv | 40 ++++
 rtl/dsi_ecc_gen.sv | 18 +
 rtl/dsi_packet_scheduler.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared types and constants for the DSI packet scheduler and its ECC helper.
package dsi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAYLOAD,
    ST_FOOTER
  } state_e;

  localparam int unsigned c_hdr_bytes = 4;
  localparam int unsigned c_ftr_bytes = 2;
  localparam logic [15:0] c_ftr_value = 16'h0000;

endpackage

// File: rtl/dsi_packet_scheduler_if.sv
// Requester, payload and packer-side signals of the DSI packet scheduler.
interface dsi_packet_scheduler_if #(
  parameter int unsigned g_input_bytes = 3
);
  localparam int unsigned W = 8 * g_input_bytes;

  logic          r0_req_i,      r1_req_i;
  logic [7:0]    r0_di_i,       r1_di_i;
  logic [15:0]   r0_wc_i,       r1_wc_i;
  logic          r0_long_i,     r1_long_i;
  logic          r0_gnt_o,      r1_gnt_o;
  logic [W-1:0]  r0_pl_i,       r1_pl_i;
  logic          r0_pl_valid_i, r1_pl_valid_i;
  logic          r0_pl_ack_o,   r1_pl_ack_o;
  logic [W-1:0]  pk_d_o;
  logic [3:0]    pk_size_o;
  logic          pk_valid_o;
  logic          pk_req_i;
  logic          pk_flush_o;
  logic          busy_o;

  // Scheduler side
  modport slave (
    input  r0_req_i, r1_req_i, r0_di_i, r1_di_i, r0_wc_i, r1_wc_i,
           r0_long_i, r1_long_i, r0_pl_i, r1_pl_i, r0_pl_valid_i, r1_pl_valid_i,
           pk_req_i,
    output r0_gnt_o, r1_gnt_o, r0_pl_ack_o, r1_pl_ack_o,
           pk_d_o, pk_size_o, pk_valid_o, pk_flush_o, busy_o
  );

  // Requesters and packer side
  modport master (
    output r0_req_i, r1_req_i, r0_di_i, r1_di_i, r0_wc_i, r1_wc_i,
           r0_long_i, r1_long_i, r0_pl_i, r1_pl_i, r0_pl_valid_i, r1_pl_valid_i,
           pk_req_i,
    input  r0_gnt_o, r1_gnt_o, r0_pl_ack_o, r1_pl_ack_o,
           pk_d_o, pk_size_o, pk_valid_o, pk_flush_o, busy_o
  );

endinterface

// File: rtl/dsi_ecc_gen.sv
// DSI header ECC: 6-bit Hamming code over {data1, data0, DI}, top two bits zero.
module dsi_ecc_gen (
  input  logic [23:0] d_i,
  output logic [7:0]  ecc_o
);

  // Each parity bit is the XOR of the header bits selected by its mask
  always_comb begin
    ecc_o    = '0;
    ecc_o[0] = ^(d_i & 24'hF12CB7);
    ecc_o[1] = ^(d_i & 24'hF2555B);
    ecc_o[2] = ^(d_i & 24'h749A6D);
    ecc_o[3] = ^(d_i & 24'hB8E38E);
    ecc_o[4] = ^(d_i & 24'hDF03F0);
    ecc_o[5] = ^(d_i & 24'hEFFC00);
  end

endmodule

// File: rtl/dsi_packet_scheduler.sv
// Arbitrates two DSI packet requesters onto one packer port: header, payload, footer, flush.
module dsi_packet_scheduler
  import dsi_pkg::*;
#(
  parameter int unsigned g_input_bytes = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  dsi_packet_scheduler_if.slave   bus
);

  localparam int unsigned W = 8 * g_input_bytes;
  localparam logic [3:0]  G = 4'(g_input_bytes);

  state_e        state_q, state_d, post_hdr;
  logic          dirty_q, dirty_d;
  logic          last_q,  last_d;
  logic          sel_q,   sel_d;
  logic [7:0]    di_q,    di_d;
  logic [15:0]   wc_q,    wc_d;
  logic          long_q,  long_d;
  logic [15:0]   rem_q,   rem_d;
  logic [1:0]    gnt_q,   gnt_d;

  logic [7:0]    ecc;
  logic [31:0]   hdr_word;
  logic          any_req, win;
  logic [3:0]    pl_size;
  logic [W-1:0]  pl_beat;
  logic          pl_valid;
  logic [W-1:0]  pk_d;
  logic [3:0]    pk_size;
  logic          pk_valid, pk_flush;
  logic [1:0]    ack;

  dsi_ecc_gen u_ecc (
    .d_i   ({wc_q[15:8], wc_q[7:0], di_q}),
    .ecc_o (ecc)
  );

  // Arbitration, header word, payload selection and post-header target
  always_comb begin
    any_req  = bus.r0_req_i | bus.r1_req_i;
    win      = (bus.r0_req_i & bus.r1_req_i) ? ~last_q : bus.r1_req_i;
    hdr_word = {di_q, wc_q[7:0], wc_q[15:8], ecc};
    pl_size  = (rem_q >= 16'(g_input_bytes)) ? G : rem_q[3:0];
    pl_beat  = sel_q ? bus.r1_pl_i : bus.r0_pl_i;
    pl_valid = sel_q ? bus.r1_pl_valid_i : bus.r0_pl_valid_i;
    post_hdr = !long_q ? ST_IDLE : ((wc_q == '0) ? ST_FOOTER : ST_PAYLOAD);
  end

  // Next-state and packer beat generation
  always_comb begin
    state_d  = state_q;
    dirty_d  = dirty_q;
    last_d   = last_q;
    sel_d    = sel_q;
    di_d     = di_q;
    wc_d     = wc_q;
    long_d   = long_q;
    rem_d    = rem_q;
    gnt_d    = '0;
    pk_d     = '0;
    pk_size  = '0;
    pk_valid = 1'b0;
    pk_flush = 1'b0;
    ack      = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_HDR0;
          sel_d   = win;
          last_d  = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          di_d    = win ? bus.r1_di_i   : bus.r0_di_i;
          wc_d    = win ? bus.r1_wc_i   : bus.r0_wc_i;
          long_d  = win ? bus.r1_long_i : bus.r0_long_i;
          rem_d   = win ? bus.r1_wc_i   : bus.r0_wc_i;
        end else if (dirty_q) begin
          pk_flush = 1'b1;
          dirty_d  = 1'b0;
        end
      end
      ST_HDR0: begin
        // Narrow packers take DI/WC now and the ECC byte in HDR1
        pk_d     = W'(hdr_word >> (32 - W));
        pk_size  = G;
        pk_valid = bus.pk_req_i;
        if (bus.pk_req_i) state_d = (g_input_bytes == 3) ? ST_HDR1 : post_hdr;
      end
      ST_HDR1: begin
        pk_d     = W'(ecc);
        pk_size  = 4'd1;
        pk_valid = bus.pk_req_i;
        if (bus.pk_req_i) state_d = post_hdr;
      end
      ST_PAYLOAD: begin
        pk_d     = pl_beat >> (8 * (g_input_bytes - 32'(pl_size)));
        pk_size  = pl_size;
        pk_valid = bus.pk_req_i & pl_valid;
        if (pk_valid) begin
          ack   = sel_q ? 2'b10 : 2'b01;
          rem_d = rem_q - 16'(pl_size);
          if (rem_q == 16'(pl_size)) state_d = ST_FOOTER;
        end
      end
      ST_FOOTER: begin
        pk_d     = W'(c_ftr_value);
        pk_size  = 4'(c_ftr_bytes);
        pk_valid = bus.pk_req_i;
        if (bus.pk_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pk_valid) dirty_d = 1'b1;
  end

  // State and latched packet fields
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      dirty_q <= 1'b0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      di_q    <= '0;
      wc_q    <= '0;
      long_q  <= 1'b0;
      rem_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      di_q    <= di_d;
      wc_q    <= wc_d;
      long_q  <= long_d;
      rem_q   <= rem_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.r0_gnt_o    = gnt_q[0];
  assign bus.r1_gnt_o    = gnt_q[1];
  assign bus.r0_pl_ack_o = ack[0];
  assign bus.r1_pl_ack_o = ack[1];
  assign bus.pk_d_o      = pk_d;
  assign bus.pk_size_o   = pk_size;
  assign bus.pk_valid_o  = pk_valid;
  assign bus.pk_flush_o  = pk_flush;
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule
